// File: rtl/grid_wb_buffered.sv
// grid_wb_buffered: gathers per-write-port grid IO results and queues complete sets toward writeback.
// Optional GRID_WB_TIMEOUT_EN forces completion of a stalled set after TIMEOUT_CYCLES collect cycles.
module grid_wb_buffered #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NUM_IO_UNITS    = 8,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef GRID_WB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 256
`endif
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_IO_UNITS*XLEN-1:0]                        io_unit_output_data,
  input  logic [NUM_IO_UNITS-1:0]                             io_unit_output_data_valid,
  input  logic [NUM_WRITE_PORTS*$clog2(NUM_IO_UNITS+1)-1:0]   io_unit_sels,
  input  logic                                                io_unit_sels_valid,
  output logic                                                sels_ready,
  output logic [NUM_WRITE_PORTS*XLEN-1:0]                     output_data,
  output logic                                                output_valid,
  input  logic                                                output_ack,
  output logic                                                wb_committing,
  output logic                                                timeout_err
);

  localparam int unsigned SEL_W = $clog2(NUM_IO_UNITS + 1);
  localparam int unsigned SET_W = NUM_WRITE_PORTS * XLEN;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_next;
  logic [NUM_WRITE_PORTS*SEL_W-1:0] r_sels;
  logic [NUM_WRITE_PORTS-1:0] r_captured;
  logic [NUM_WRITE_PORTS-1:0] w_captured_next;
  logic [SET_W-1:0]           r_cap;
  logic [SET_W-1:0]           w_cap_next;
  logic                       w_all_done;
  logic                       w_tmo;

  logic [SET_W-1:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;

  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop         = output_valid && output_ack;
  assign w_push        = (r_state == COMMIT) && (!w_full || w_pop);
  assign sels_ready    = (r_state == IDLE);
  assign output_valid  = (r_count != '0);
  assign output_data   = r_mem[r_rd_ptr];
  assign wb_committing = w_pop;

  // Per-port capture: unused select or valid selected unit captures; timeout fills remaining ports with 0.
  always_comb begin
    w_captured_next = r_captured;
    w_cap_next      = r_cap;
    w_all_done      = 1'b1;
    for (int p = 0; p < int'(NUM_WRITE_PORTS); p++) begin : g_port
      logic [SEL_W-1:0] sel;
      logic             hit;
      logic [XLEN-1:0]  hit_data;
      sel      = r_sels[p*SEL_W +: SEL_W];
      hit      = 1'b0;
      hit_data = '0;
      if (sel >= SEL_W'(NUM_IO_UNITS)) begin
        hit = 1'b1;
      end else begin
        for (int u = 0; u < int'(NUM_IO_UNITS); u++) begin
          if (sel == SEL_W'(u) && io_unit_output_data_valid[u]) begin
            hit      = 1'b1;
            hit_data = io_unit_output_data[u*XLEN +: XLEN];
          end
        end
      end
      if (!r_captured[p] && (hit || w_tmo)) begin
        w_captured_next[p]           = 1'b1;
        w_cap_next[p*XLEN +: XLEN]   = hit ? hit_data : '0;
      end
      w_all_done = w_all_done && w_captured_next[p];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (io_unit_sels_valid) w_state_next = COLLECT;
      COLLECT: if (w_all_done)         w_state_next = COMMIT;
      COMMIT:  if (w_push)             w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sels     <= '0;
      r_captured <= '0;
      r_cap      <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && io_unit_sels_valid) begin
        r_sels     <= io_unit_sels;
        r_captured <= '0;
      end else if (r_state == COLLECT) begin
        r_captured <= w_captured_next;
        r_cap      <= w_cap_next;
      end
    end
  end

  // Show-ahead FIFO; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_cap;
  end

`ifdef GRID_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;

  assign w_tmo       = (r_state == COLLECT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE && io_unit_sels_valid) r_tmo_cnt <= '0;
      else if (r_state == COLLECT)               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_tmo) r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_grid_wb_buffered.sv
// tb_grid_wb_buffered: directed scoreboard bench for grid_wb_buffered (latency, FIFO full/wrap, reset, timeout).
module tb_grid_wb_buffered;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NIO   = 8;
  localparam int unsigned NWP   = 2;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned SET_W = NWP * XLEN;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NIO*XLEN-1:0]   io_data;
  logic [NIO-1:0]        io_valid;
  logic [NWP*SEL_W-1:0]  sels;
  logic                  sels_valid;
  logic                  sels_ready;
  logic [SET_W-1:0]      output_data;
  logic                  output_valid;
  logic                  output_ack;
  logic                  wb_committing;
  logic                  timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  logic [SET_W-1:0] sb [$];

  always #5 clk = ~clk;

  grid_wb_buffered #(
    .XLEN(XLEN), .NUM_IO_UNITS(NIO), .NUM_WRITE_PORTS(NWP), .FIFO_DEPTH(4)
`ifdef GRID_WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .io_unit_output_data(io_data), .io_unit_output_data_valid(io_valid),
    .io_unit_sels(sels), .io_unit_sels_valid(sels_valid), .sels_ready(sels_ready),
    .output_data(output_data), .output_valid(output_valid), .output_ack(output_ack),
    .wb_committing(wb_committing), .timeout_err(timeout_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [SET_W-1:0] obs, input logic [SET_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive_unit(input int u, input logic [XLEN-1:0] d);
    io_data[u*XLEN +: XLEN] = d;
    io_valid[u] = 1'b1;
  endtask

  task automatic clear_units();
    io_valid = '0;
  endtask

  // Waits for IDLE, offers a select set; returns one cycle later (first COLLECT cycle).
  task automatic offer(input int s0, input int s1);
    int k;
    k = 0;
    while (sels_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk1("sels_ready_wait", sels_ready, 1'b1);
    sels       = {SEL_W'(s1), SEL_W'(s0)};
    sels_valid = 1'b1;
    step();
    sels_valid = 1'b0;
  endtask

  task automatic offer_set(input int s0, input int s1, input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    logic [XLEN-1:0] e0, e1;
    offer(s0, s1);
    if (s0 < int'(NIO)) drive_unit(s0, d0);
    if (s1 < int'(NIO)) drive_unit(s1, d1);
    e0 = (s0 < int'(NIO)) ? d0 : '0;
    e1 = (s1 < int'(NIO)) ? d1 : '0;
    sb.push_back({e1, e0});
    step();
    clear_units();
  endtask

  task automatic pop_check(input string tag);
    int k;
    logic [SET_W-1:0] exp;
    k = 0;
    while (output_valid !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk1({tag, "_valid"}, output_valid, 1'b1);
    if (sb.size() != 0) exp = sb.pop_front();
    else exp = '1;
    chk(tag, output_data, exp);
    output_ack = 1'b1;
    #1;
    chk1({tag, "_commit"}, wb_committing, 1'b1);
    step();
    output_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    io_data    = '0;
    io_valid   = '0;
    sels       = '0;
    sels_valid = 1'b0;
    output_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk1("rst_sels_ready", sels_ready, 1'b1);
    chk1("rst_output_valid", output_valid, 1'b0);
    chk1("rst_wb_committing", wb_committing, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);

    // Staggered arrival: unit3 at T+1, unit5 at T+4, stray unit3 pulse ignored.
    offer(3, 5);
    drive_unit(3, 32'h11);
    chk1("t1_ready_low", sels_ready, 1'b0);
    step(); clear_units();
    chk1("t1_ov_t2", output_valid, 1'b0);
    step(); drive_unit(3, 32'h99);
    chk1("t1_ov_t3", output_valid, 1'b0);
    step(); clear_units(); drive_unit(5, 32'h22);
    chk1("t1_ov_t4", output_valid, 1'b0);
    step(); clear_units();
    chk1("t1_ov_t5", output_valid, 1'b0);
    sb.push_back({32'h22, 32'h11});
    step();
    chk1("t1_ov_t6", output_valid, 1'b1);
    pop_check("t1_set");
    chk1("t1_empty", output_valid, 1'b0);

    // Unused port writes 0; minimum latency.
    offer(2, int'(NIO));
    drive_unit(2, 32'hAB);
    step(); clear_units();
    chk1("t2_ov_t2", output_valid, 1'b0);
    sb.push_back({32'h0, 32'hAB});
    step();
    chk1("t2_ov_t3", output_valid, 1'b1);
    pop_check("t2_set");

    // Fill FIFO with ack held low; fifth set stalls in COMMIT.
    for (int i = 0; i < 5; i++) offer_set(4, 6, 32'h100 + i, 32'h200 + i);
    step(); step();
    chk1("t3_stall_ready", sels_ready, 1'b0);
    chk1("t3_full_valid", output_valid, 1'b1);
    pop_check("t3_pop0");
    chk1("t3_ready_after_push", sels_ready, 1'b1);

    // Full FIFO, push+pop same cycle with duplicate selects, then drain across wrap.
    offer_set(6, 6, 32'h300, 32'h300);
    step();
    chk1("t4_stall_ready", sels_ready, 1'b0);
    pop_check("t4_pop1");
    for (int i = 0; i < 4; i++) pop_check($sformatf("t4_drain%0d", i));
    chk1("t4_empty", output_valid, 1'b0);

    // Reset mid-COLLECT with port0 captured; next set must wait for fresh port0 data.
    offer(1, 7);
    drive_unit(1, 32'h55);
    step(); clear_units();
    chk1("t5_ov_pre", output_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("t5_rst_ready", sels_ready, 1'b1);
    chk1("t5_rst_ov", output_valid, 1'b0);
    offer(1, 7);
    drive_unit(7, 32'h77);
    step(); clear_units();
    chk1("t5_no_stale_t2", output_valid, 1'b0);
    step();
    chk1("t5_no_stale_t3", output_valid, 1'b0);
    drive_unit(1, 32'h66);
    step(); clear_units();
    chk1("t5_ov_t4", output_valid, 1'b0);
    sb.push_back({32'h77, 32'h66});
    step();
    chk1("t5_ov_t5", output_valid, 1'b1);
    pop_check("t5_set");

    // Ack while empty is ignored.
    output_ack = 1'b1;
    step(); step();
    chk1("t6_empty_ov", output_valid, 1'b0);
    chk1("t6_empty_commit", wb_committing, 1'b0);
    output_ack = 1'b0;
    offer_set(0, 1, 32'hA0, 32'hA1);
    pop_check("t6_set");
    chk1("t6_empty_after", output_valid, 1'b0);

`ifdef GRID_WB_TIMEOUT_EN
    // Unit1 never valid: forced completion at counter 7, sticky error.
    offer(0, 1);
    drive_unit(0, 32'hC0);
    step(); clear_units();
    repeat (6) step();
    chk1("t7_err_t8", timeout_err, 1'b0);
    chk1("t7_ov_t8", output_valid, 1'b0);
    step();
    chk1("t7_err_t9", timeout_err, 1'b1);
    sb.push_back({32'h0, 32'hC0});
    step();
    chk1("t7_ov_t10", output_valid, 1'b1);
    pop_check("t7_set");
    repeat (3) step();
    chk1("t7_err_sticky", timeout_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("t7_err_cleared", timeout_err, 1'b0);
`else
    // Without timeout, COLLECT waits indefinitely.
    offer(0, 1);
    drive_unit(0, 32'hC0);
    step(); clear_units();
    repeat (20) step();
    chk1("t7_wait_ready", sels_ready, 1'b0);
    chk1("t7_wait_ov", output_valid, 1'b0);
    chk1("t7_wait_err", timeout_err, 1'b0);
    drive_unit(1, 32'hC1);
    step(); clear_units();
    sb.push_back({32'hC1, 32'hC0});
    pop_check("t7_set");
`endif

    chk("sb_drained", SET_W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
